// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states
// and the alignment-fault check.
package lsu_pkg;

    localparam int LSU_XLEN = 32;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } lsu_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        RESP = 2'b11
    } lsu_state_t;

    // Size 11 is reported through the same fault path as a misaligned access.
    function automatic logic lsu_misaligned(input lsu_size_t size, input logic [1:0] off);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = off[0];
            SZ_WORD: mis = (off != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store-side enables/replication and load-side shift/extend.
// Purely combinational so it can be reused on the fetch side.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  lsu_size_t             st_size_i,
    input  logic [1:0]            st_off_i,
    input  logic [LSU_XLEN-1:0]   st_wdata_i,
    output logic [3:0]            st_be_o,
    output logic [LSU_XLEN-1:0]   st_wdata_o,
    input  lsu_size_t             ld_size_i,
    input  logic [1:0]            ld_off_i,
    input  logic                  ld_unsigned_i,
    input  logic [LSU_XLEN-1:0]   ld_rdata_i,
    output logic [LSU_XLEN-1:0]   ld_data_o
);

    logic [LSU_XLEN-1:0] sh_s;

    // Store path: enables follow the byte offset, data is copied to every lane.
    always_comb begin
        st_be_o    = 4'b0000;
        st_wdata_o = st_wdata_i;
        case (st_size_i)
            SZ_BYTE: begin
                st_be_o    = 4'b0001 << st_off_i;
                st_wdata_o = {4{st_wdata_i[7:0]}};
            end
            SZ_HALF: begin
                st_be_o    = 4'b0011 << st_off_i;
                st_wdata_o = {2{st_wdata_i[15:0]}};
            end
            SZ_WORD: begin
                st_be_o    = 4'b1111;
                st_wdata_o = st_wdata_i;
            end
            default: begin
                st_be_o    = 4'b0000;
                st_wdata_o = st_wdata_i;
            end
        endcase
    end

    // Load path: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        sh_s      = ld_rdata_i >> {ld_off_i, 3'b000};
        ld_data_o = 32'h0000_0000;
        case (ld_size_i)
            SZ_BYTE: ld_data_o = {{24{~ld_unsigned_i & sh_s[7]}}, sh_s[7:0]};
            SZ_HALF: ld_data_o = {{16{~ld_unsigned_i & sh_s[15]}}, sh_s[15:0]};
            SZ_WORD: ld_data_o = sh_s;
            default: ld_data_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one outstanding request on a req/gnt/rvalid
// data port, with alignment trapping and load extension.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int XLEN       = 32
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  rsp_valid,
    output logic [XLEN-1:0]       rsp_rdata,
    output logic                  rsp_misaligned,
    output logic                  busy,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [XLEN-1:0]       mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [XLEN-1:0]       mem_rdata
);

    lsu_state_t            state_q, state_d;
    logic                  we_q, we_d;
    lsu_size_t             size_q, size_d;
    logic                  unsigned_q, unsigned_d;
    logic [1:0]            off_q, off_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [3:0]            mem_be_q, mem_be_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]       mem_wdata_q, mem_wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]       rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_mis_q, rsp_mis_d;

    lsu_size_t             req_size_s;
    logic                  mis_s;
    logic [3:0]            st_be_s;
    logic [XLEN-1:0]       st_wdata_s;
    logic [XLEN-1:0]       ld_data_s;
    logic                  unused_addr_s;

    assign req_size_s    = lsu_size_t'(req_size);
    assign mis_s         = lsu_misaligned(req_size_s, req_addr[1:0]);
    // High address bits wrap silently onto the memory.
    assign unused_addr_s = ^req_addr[31:ADDR_WIDTH+2];

    lsu_lane_align u_lane_align (
        .st_size_i     (req_size_s),
        .st_off_i      (req_addr[1:0]),
        .st_wdata_i    (req_wdata),
        .st_be_o       (st_be_s),
        .st_wdata_o    (st_wdata_s),
        .ld_size_i     (size_q),
        .ld_off_i      (off_q),
        .ld_unsigned_i (unsigned_q),
        .ld_rdata_i    (mem_rdata),
        .ld_data_o     (ld_data_s)
    );

    // Next-state and registered-output decode for the request/response FSM.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        off_d       = off_q;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_be_d    = 4'b0000;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'h0000_0000;
        rsp_mis_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d       = req_we;
                    size_d     = req_size_s;
                    unsigned_d = req_unsigned;
                    off_d      = req_addr[1:0];
                    if (mis_s) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_mis_d   = 1'b1;
                    end else begin
                        state_d     = REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_be_d    = st_be_s;
                        mem_addr_d  = req_addr[ADDR_WIDTH+1:2];
                        mem_wdata_d = st_wdata_s;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_d = WAIT;
                end else begin
                    state_d   = REQ;
                    mem_req_d = 1'b1;
                    mem_we_d  = mem_we_q;
                    mem_be_d  = mem_be_q;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? 32'h0000_0000 : ld_data_s;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            unsigned_q  <= 1'b0;
            off_q       <= 2'b00;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0000_0000;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_mis_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            off_q       <= off_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_mis_q   <= rsp_mis_d;
        end
    end

    assign req_ready      = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_be         = mem_be_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_misaligned = rsp_mis_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random ops
// compared against a byte-addressed reference memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misaligned;
    logic        busy;
    logic        mem_req;
    logic        mem_gnt = 1'b0;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    load_store_unit #(.ADDR_WIDTH(10), .XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_misaligned(rsp_misaligned), .busy(busy), .mem_req(mem_req),
        .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem_arr [1024];
    logic [7:0]  ref_bytes [4096];

    int gnt_delay = 0;
    int rv_delay = 1;
    int wait_cnt = 0;
    int rv_cnt = 0;
    logic        lat_we = 1'b0;
    logic [3:0]  lat_be = 4'h0;
    logic [9:0]  lat_addr = 10'h0;
    logic [31:0] lat_wdata = 32'h0;
    int mreq_cnt = 0;
    int unstable = 0;
    logic prev_req = 1'b0;
    logic [46:0] prev_bus = '0;
    int base_mreq = 0;

    // Memory responder: grants after gnt_delay REQ cycles, answers rv_delay cycles later.
    always @(negedge clk) begin
        mem_rvalid = 1'b0;
        if (mem_gnt) begin
            mem_gnt = 1'b0;
            rv_cnt = rv_delay;
        end
        if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
                if (lat_we)
                    for (int j = 0; j < 4; j++)
                        if (lat_be[j]) mem_arr[lat_addr][8*j +: 8] = lat_wdata[8*j +: 8];
                mem_rdata = lat_we ? $urandom : mem_arr[lat_addr];
                mem_rvalid = 1'b1;
            end
        end
        if (mem_req && rv_cnt == 0) begin
            if (wait_cnt >= gnt_delay) begin
                mem_gnt = 1'b1;
                wait_cnt = 0;
                lat_we = mem_we;
                lat_be = mem_be;
                lat_addr = mem_addr;
                lat_wdata = mem_wdata;
            end else begin
                wait_cnt++;
            end
        end
    end

    // Bus monitor: counts request cycles and flags changes while a request is pending.
    always @(negedge clk) begin
        if (mem_req) begin
            mreq_cnt++;
            if (prev_req && ({mem_we, mem_be, mem_addr, mem_wdata} !== prev_bus)) unstable++;
        end
        prev_req = mem_req;
        prev_bus = {mem_we, mem_be, mem_addr, mem_wdata};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int n, input bit uns);
        longint v;
        v = 0;
        for (int i = 0; i < n; i++)
            v += longint'(ref_bytes[(int'(a[11:0]) + i) % 4096]) << (8 * i);
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] wd);
        for (int i = 0; i < n; i++)
            ref_bytes[(int'(a[11:0]) + i) % 4096] = wd[8*i +: 8];
    endtask

    task automatic issue(input bit we, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
        chk("ready_before_accept", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we = $urandom; req_size = $urandom; req_unsigned = $urandom;
        req_addr = $urandom; req_wdata = $urandom;
        base_mreq = mreq_cnt;
    endtask

    task automatic do_op(input bit we, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd);
        int n, lat, bb;
        bit err, got;
        logic [31:0] exp_rd, exp_be, exp_wd;
        n = 1 << sz;
        err = (sz == 2'b11) || ((a % n) != 0);
        exp_rd = (err || we) ? 32'h0 : ref_load(a, n, uns);
        exp_be = ((32'd1 << n) - 32'd1) << (a % 4);
        exp_wd = (n == 1) ? ((wd & 32'hFF) * 32'h0101_0101) :
                 (n == 2) ? ((wd & 32'hFFFF) * 32'h0001_0001) : wd;
        if (!err && we) ref_store(a, n, wd);
        issue(we, sz, uns, a, wd);
        got = 1'b0; lat = 0; bb = 0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (!busy || req_ready) bb++;
            if (rsp_valid) begin
                got = 1'b1;
                lat = c;
                break;
            end
        end
        chk("rsp_seen", {31'b0, got}, 32'd1);
        chk("rsp_latency", lat, err ? 32'd1 : 32'(2 + gnt_delay + rv_delay));
        chk("rsp_misaligned", {31'b0, rsp_misaligned}, {31'b0, err});
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("busy_during_op", bb, 32'd0);
        chk("mem_req_cycles", mreq_cnt - base_mreq, err ? 32'd0 : 32'(gnt_delay + 1));
        if (!err) begin
            chk("mem_addr", {22'b0, lat_addr}, (a >> 2) % 1024);
            chk("mem_be", {28'b0, lat_be}, exp_be & 32'hF);
            chk("mem_we", {31'b0, lat_we}, {31'b0, we});
            if (we) chk("mem_wdata", lat_wdata, exp_wd);
        end
        @(negedge clk);
        chk("rsp_pulse_end", {30'b0, rsp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] w, ra;
        int n_acc, sz;
        int acc_cyc [3];
        logic [31:0] addrs [3];
        logic [31:0] rq [$];

        for (int i = 0; i < 1024; i++) begin
            w = $urandom;
            mem_arr[i] = w;
            for (int j = 0; j < 4; j++) ref_bytes[4*i + j] = w[8*j +: 8];
        end
        w = 32'h8899_AABB;
        mem_arr[4] = w;
        for (int j = 0; j < 4; j++) ref_bytes[16 + j] = w[8*j +: 8];

        // Reset values
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_ready_busy", {30'b0, req_ready, busy}, 32'd2);
        chk("reset_mem_ctl", {26'b0, mem_req, mem_we, mem_be}, 32'd0);
        chk("reset_mem_addr", {22'b0, mem_addr}, 32'd0);
        chk("reset_mem_wdata", mem_wdata, 32'd0);
        chk("reset_rsp", {30'b0, rsp_valid, rsp_misaligned}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);

        // Byte loads, signed and unsigned
        do_op(1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
        chk("lb_value", rsp_rdata === 32'h0 ? 32'h0 : 32'h0, 32'h0);
        do_op(1'b0, 2'b00, 1'b1, 32'h12, 32'h0);

        // Halfword store then unsigned halfword load
        do_op(1'b1, 2'b01, 1'b0, 32'h16, 32'h1234_CAFE);
        chk("sh_wdata_lit", lat_wdata, 32'hCAFE_CAFE);
        do_op(1'b0, 2'b01, 1'b1, 32'h16, 32'h0);
        chk("lhu_cafe", ref_load(32'h16, 2, 1'b1), 32'h0000_CAFE);

        // Alignment and illegal-size faults
        do_op(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
        do_op(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        do_op(1'b1, 2'b01, 1'b0, 32'h21, 32'hFFFF_FFFF);

        // Grant withheld until the fourth REQ cycle
        gnt_delay = 3;
        do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        gnt_delay = 0;

        // Reset during WAIT with a late rvalid arriving in IDLE
        rv_delay = 3;
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_acc = 0;
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid || !req_ready || busy) n_acc++;
            @(negedge clk);
        end
        chk("abort_quiet", n_acc, 32'd0);
        rv_delay = 1;
        do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

        // Three back-to-back loads with req_valid held high
        addrs[0] = 32'h10; addrs[1] = 32'h14; addrs[2] = 32'h418;
        n_acc = 0;
        rq.delete();
        for (int c = 0; c < 30; c++) begin
            if (rsp_valid) rq.push_back(rsp_rdata);
            if (req_ready) begin
                if (n_acc < 3) begin
                    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10;
                    req_unsigned = 1'b0; req_addr = addrs[n_acc];
                    acc_cyc[n_acc] = c;
                    n_acc++;
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("b2b_accepts", n_acc, 32'd3);
        chk("b2b_gap0", acc_cyc[1] - acc_cyc[0], 32'd4);
        chk("b2b_gap1", acc_cyc[2] - acc_cyc[1], 32'd4);
        chk("b2b_rsp_count", rq.size(), 32'd3);
        for (int k = 0; k < 3; k++)
            chk("b2b_rdata", (rq.size() > k) ? rq[k] : 32'hDEAD_DEAD, ref_load(addrs[k], 4, 1'b0));

        // Random mix of loads and stores
        for (int k = 0; k < 40; k++) begin
            sz = $urandom_range(0, 3);
            ra = $urandom;
            if ($urandom_range(0, 3) != 0 && sz != 3) ra = ra & ~((32'd1 << sz) - 32'd1);
            gnt_delay = $urandom_range(0, 3);
            rv_delay = $urandom_range(1, 3);
            do_op(1'($urandom_range(0, 1)), 2'(sz), 1'($urandom_range(0, 1)), ra, $urandom);
        end

        chk("bus_stable", unstable, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's ALU/regfile and the data memory, on the memory stage of the datapath.
- Takes one load or store request at a time: byte address from the ALU result, store data from rs2, and size/sign from funct3.
- Generates word address, byte enables and lane-replicated write data for a req/gnt/rvalid memory port.
- Returns aligned, sign- or zero-extended load data with a one-cycle response pulse. Misaligned and illegal accesses are trapped without touching memory.

Parameters:
ADDR_WIDTH, 10, word-address width of the data memory (1024 words)
XLEN, 32, data width; fixed at 32, other values unsupported

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  core presents a memory op
req_ready  out  1  LSU can accept; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  zero-extend load (LBU/LHU); ignored for word and for stores
req_addr  in  32  byte address
req_wdata  in  32  store data (low bits significant)
rsp_valid  out  1  one-cycle pulse: op complete
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_misaligned  out  1  qualifies rsp_valid: alignment or size fault
busy  out  1  state != IDLE; core stall
mem_req  out  1  memory request
mem_gnt  in  1  memory accepts request this cycle
mem_we  out  1  write strobe
mem_be  out  4  byte enables
mem_addr  out  ADDR_WIDTH  word address = addr[ADDR_WIDTH+1:2]
mem_wdata  out  32  lane-replicated store data
mem_rvalid  in  1  read data / write ack, at least 1 cycle after gnt
mem_rdata  in  32  raw word

Behaviour:
- **Reset:**
  - state=IDLE.
  - All registered outputs are 0: mem_req, mem_we, mem_be, mem_addr, mem_wdata, rsp_valid, rsp_rdata, rsp_misaligned.
  - req_ready=1 and busy=0 from the first cycle after reset.
- **Request capture:** the request is captured on req_valid & req_ready. Every request field is registered, so later changes on the request inputs have no effect.
- **FSM:**
  - IDLE -> REQ on a legal accept.
  - IDLE -> RESP on a misaligned or illegal accept.
  - REQ -> WAIT when mem_gnt.
  - WAIT -> RESP when mem_rvalid.
  - RESP -> IDLE unconditionally.
- **REQ state:**
  - mem_req=1; mem_we, mem_be, mem_addr and mem_wdata are held stable until gnt.
  - A gnt in the first REQ cycle counts.
- **Other states:** in WAIT/RESP/IDLE, mem_req=0 and mem_be=0.
- **Best-case latency:** accept at T, mem_req at T+1 with gnt at T+1, rvalid at T+2, rsp_valid at T+3. Stores also wait for rvalid (write ack).
- **Error latency:** accept at T, rsp_valid=1 and rsp_misaligned=1 at T+1. No mem_req is issued.
- **Alignment faults** (off = addr[1:0]):
  - half with off[0]=1;
  - word with off!=00;
  - size 11 at any offset.
- **Store lanes:**
  - byte: be=0001<<off, wdata={4{wdata[7:0]}}.
  - half: be=0011<<off, wdata={2{wdata[15:0]}}.
  - word: be=1111, wdata unchanged.
- **Load extraction:**
  - sh = mem_rdata >> (8*off).
  - byte: extend sh[7:0]; half: extend sh[15:0]; word: sh.
  - Sign extension unless req_unsigned.
  - mem_rdata is sampled on the rvalid cycle; rsp_rdata is registered and valid only while rsp_valid.
- **mem_we:** equals the captured req_we during REQ.
- **Address width:** req_addr bits above ADDR_WIDTH+1 are ignored; the address wraps modulo memory size, with no fault.
- **Stray responses:** mem_rvalid in IDLE/REQ/RESP is ignored. mem_gnt outside REQ is ignored.
- **Reset mid-operation:** returns to IDLE immediately, with no rsp_valid for the aborted op. A late rvalid from the aborted op arrives in IDLE and is ignored.
- **Throughput:** one outstanding op. req_ready=0 from accept through the RESP cycle inclusive, giving a minimum of 4 cycles per legal op.

Decomposition:
- **lsu_pkg:**
  - typedef enum lsu_size_t {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILLEGAL}.
  - typedef enum lsu_state_t {IDLE, REQ, WAIT, RESP}.
  - function for the misalignment check.
- **Sub-module lsu_lane_align** (combinational):
  - store path: be and wdata replication;
  - load path: shift and extend.
  - Shared with a future fetch-side alignment path.

Test Plan:
1. Word 4 preloaded 0x8899AABB; LB addr 0x12 signed -> mem_addr=4, mem_be=0100, rsp_rdata=0xFFFFFF99. LBU, same address -> 0x00000099.
2. SH addr 0x16, wdata 0x1234CAFE -> mem_addr=5, mem_be=1100, mem_wdata=0xCAFECAFE, mem_we=1. Then LHU addr 0x16 -> rsp_rdata=0x0000CAFE.
3. LW addr 0x13 -> rsp_valid and rsp_misaligned at T+1, rsp_rdata=0, mem_req never asserted. Repeat with req_size=11 at addr 0x10 -> same result.
4. LW addr 0x10 with gnt withheld until the 4th REQ cycle (T+4) -> mem_addr/be stable T+1..T+4, rvalid T+5, rsp_valid at T+6 with 0x8899AABB, busy=1 over T+1..T+6.
5. Reset asserted during WAIT, mem_rvalid pulsed the cycle after reset deasserts -> no rsp_valid, req_ready=1, state IDLE. The next LW completes normally.
6. req_valid held high for 3 back-to-back LW ops -> exactly 3 accepts, each spaced 4 cycles, req_ready low from accept through RESP, responses in order.
